// File: rtl/deconv_pkg.sv
// Shared defaults, one-hot state encoding and error-bit indices for the deconv block.
package deconv_pkg;

    localparam int unsigned LEN_DEF   = 8;
    localparam int unsigned ACC_W_DEF = 24;

    localparam int unsigned ERR_DIV = 0;
    localparam int unsigned ERR_RES = 1;

    typedef enum logic [6:0] {
        S_LOAD = 7'b0000001,
        S_INIT = 7'b0000010,
        S_MAC  = 7'b0000100,
        S_DIV  = 7'b0001000,
        S_WB   = 7'b0010000,
        S_RES  = 7'b0100000,
        S_OUT  = 7'b1000000
    } state_e;

    // Sub-steps of one residue sample: load y[n], accumulate, then compare against zero.
    typedef enum logic [1:0] {
        RP_INIT,
        RP_MAC,
        RP_CMP
    } res_phase_e;

endpackage

// File: rtl/deconv_div.sv
// deconv_div: signed sequential restoring divider with a fixed ACC_W-cycle latency.
// The quotient is truncated toward zero; signs are stripped on start and reapplied on output.
module deconv_div #(
    parameter int unsigned ACC_W = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_i,
    input  logic signed [ACC_W-1:0] dividend_i,
    input  logic signed [7:0]       divisor_i,
    output logic                    done_o,
    output logic signed [ACC_W:0]   quotient_o
);

    localparam int unsigned CW = $clog2(ACC_W);

    logic             busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [7:0]       rem_q, rem_d;
    logic [ACC_W-1:0] quo_q, quo_d;
    logic [7:0]       dsr_q, dsr_d;
    logic             neg_q, neg_d;
    logic [8:0]       rem_sh;

    // done marks the cycle in which the final quotient bit is being resolved.
    assign done_o     = busy_q && (cnt_q == CW'(ACC_W - 1));
    assign quotient_o = neg_q ? -$signed({1'b0, quo_q}) : $signed({1'b0, quo_q});

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        dsr_d  = dsr_q;
        neg_d  = neg_q;
        rem_sh = {rem_q, quo_q[ACC_W-1]};
        if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            rem_d  = '0;
            quo_d  = dividend_i[ACC_W-1] ? ACC_W'(-dividend_i) : dividend_i;
            dsr_d  = divisor_i[7] ? 8'(-divisor_i) : divisor_i;
            neg_d  = dividend_i[ACC_W-1] ^ divisor_i[7];
        end else if (busy_q) begin
            if (rem_sh >= {1'b0, dsr_q}) begin
                rem_d = 8'(rem_sh - {1'b0, dsr_q});
                quo_d = {quo_q[ACC_W-2:0], 1'b1};
            end else begin
                rem_d = rem_sh[7:0];
                quo_d = {quo_q[ACC_W-2:0], 1'b0};
            end
            cnt_d = cnt_q + CW'(1);
            if (done_o) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dsr_q  <= '0;
            neg_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dsr_q  <= dsr_d;
            neg_q  <= neg_d;
        end
    end

endmodule

// File: rtl/deconv.sv
// deconv: recovers x from a full convolution frame y and kernel h by recursive long division.
// Define DECONV_RESIDUE_CHECK_EN to build the residue check over y[LEN..2*LEN-2].
module deconv
    import deconv_pkg::*;
#(
    parameter int unsigned LEN   = LEN_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        DECONV_iValid,
    output logic        DECONV_iReady,
    input  logic [15:0] DECONV_iY,
    input  logic [7:0]  DECONV_iH,
    output logic        DECONV_oValid,
    input  logic        DECONV_iOutReady,
    output logic [7:0]  DECONV_oX,
    output logic        DECONV_oLast,
    output logic [1:0]  DECONV_oErr
);

    localparam int unsigned NY = 2 * LEN - 1;
    localparam int unsigned LW = $clog2(LEN);
    localparam int unsigned IW = $clog2(NY);
    localparam logic signed [ACC_W:0] Q_MAX = 127;
    localparam logic signed [ACC_W:0] Q_MIN = -128;

    state_e                  state_q, state_d;
    logic [IW-1:0]           n_q, n_d;
    logic [LW-1:0]           k_q, k_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [1:0]              err_q, err_d;
`ifdef DECONV_RESIDUE_CHECK_EN
    res_phase_e              rph_q, rph_d;
`endif

    logic [15:0]             y_q [NY];
    logic signed [7:0]       h_q [LEN];
    logic signed [7:0]       x_q [LEN];

    logic                    y_we, h_we, x_we, x_clr;
    logic signed [7:0]       x_wdata;
    logic signed [15:0]      y_rd;
    logic signed [15:0]      prod;
    logic signed [ACC_W-1:0] y_ext, prod_ext;
    logic [LW-1:0]           j_idx;
    logic                    in_fire, out_fire;
    logic                    div_start, div_done;
    logic signed [ACC_W:0]   div_q;

    deconv_div #(
        .ACC_W(ACC_W)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .start_i   (div_start),
        .dividend_i(acc_d),
        .divisor_i (h_q[0]),
        .done_o    (div_done),
        .quotient_o(div_q)
    );

    // n-k stays below LEN, so modulo-2^LW arithmetic on the low index bits is exact.
    always_comb begin
        y_rd     = y_q[n_q];
        y_ext    = {{(ACC_W-16){y_rd[15]}}, y_rd};
        j_idx    = n_q[LW-1:0] - k_q;
        prod     = 16'(h_q[k_q]) * 16'(x_q[j_idx]);
        prod_ext = {{(ACC_W-16){prod[15]}}, prod};
    end

    always_comb begin
        DECONV_iReady = reset && (state_q == S_LOAD);
        DECONV_oValid = reset && (state_q == S_OUT);
        DECONV_oX     = DECONV_oValid ? x_q[n_q[LW-1:0]] : '0;
        DECONV_oLast  = DECONV_oValid && (n_q == IW'(LEN - 1));
        DECONV_oErr   = DECONV_oValid ? err_q : '0;
        in_fire       = DECONV_iValid && DECONV_iReady;
        out_fire      = DECONV_oValid && DECONV_iOutReady;
    end

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        k_d       = k_q;
        acc_d     = acc_q;
        err_d     = err_q;
`ifdef DECONV_RESIDUE_CHECK_EN
        rph_d     = rph_q;
`endif
        y_we      = 1'b0;
        h_we      = 1'b0;
        x_we      = 1'b0;
        x_clr     = 1'b0;
        x_wdata   = '0;
        div_start = 1'b0;
        unique case (state_q)
            S_LOAD: begin
                if (in_fire) begin
                    y_we = 1'b1;
                    h_we = (n_q < IW'(LEN));
                    if (n_q == IW'(NY - 1)) begin
                        n_d = '0;
                        if (h_q[0] == '0) begin
                            err_d[ERR_DIV] = 1'b1;
                            x_clr          = 1'b1;
                            state_d        = S_OUT;
                        end else begin
                            state_d = S_INIT;
                        end
                    end else begin
                        n_d = n_q + IW'(1);
                    end
                end
            end
            S_INIT: begin
                acc_d = y_ext;
                k_d   = LW'(1);
                if (n_q == '0) begin
                    div_start = 1'b1;
                    state_d   = S_DIV;
                end else begin
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = acc_q - prod_ext;
                if (k_q == n_q[LW-1:0]) begin
                    div_start = 1'b1;
                    state_d   = S_DIV;
                end else begin
                    k_d = k_q + LW'(1);
                end
            end
            S_DIV: begin
                if (div_done) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                x_we = 1'b1;
                if (div_q > Q_MAX) begin
                    x_wdata        = 8'h7F;
                    err_d[ERR_DIV] = 1'b1;
                end else if (div_q < Q_MIN) begin
                    x_wdata        = 8'h80;
                    err_d[ERR_DIV] = 1'b1;
                end else begin
                    x_wdata = div_q[7:0];
                end
                if (n_q == IW'(LEN - 1)) begin
`ifdef DECONV_RESIDUE_CHECK_EN
                    n_d     = IW'(LEN);
                    rph_d   = RP_INIT;
                    state_d = S_RES;
`else
                    n_d     = '0;
                    state_d = S_OUT;
`endif
                end else begin
                    n_d     = n_q + IW'(1);
                    state_d = S_INIT;
                end
            end
`ifdef DECONV_RESIDUE_CHECK_EN
            S_RES: begin
                unique case (rph_q)
                    RP_INIT: begin
                        acc_d = y_ext;
                        k_d   = n_q[LW-1:0] - LW'(LEN - 1);
                        rph_d = RP_MAC;
                    end
                    RP_MAC: begin
                        acc_d = acc_q - prod_ext;
                        if (k_q == LW'(LEN - 1)) begin
                            rph_d = RP_CMP;
                        end else begin
                            k_d = k_q + LW'(1);
                        end
                    end
                    default: begin
                        if (acc_q != '0) begin
                            err_d[ERR_RES] = 1'b1;
                        end
                        if (n_q == IW'(NY - 1)) begin
                            n_d     = '0;
                            state_d = S_OUT;
                        end else begin
                            n_d   = n_q + IW'(1);
                            rph_d = RP_INIT;
                        end
                    end
                endcase
            end
`endif
            S_OUT: begin
                if (out_fire) begin
                    if (n_q == IW'(LEN - 1)) begin
                        n_d     = '0;
                        err_d   = '0;
                        state_d = S_LOAD;
                    end else begin
                        n_d = n_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_LOAD;
            n_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
        end
    end

`ifdef DECONV_RESIDUE_CHECK_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            rph_q <= RP_INIT;
        end else begin
            rph_q <= rph_d;
        end
    end
`endif

    // Sample storage is fully rewritten by every frame, so it carries no reset.
    always_ff @(posedge clk) begin
        if (y_we) begin
            y_q[n_q] <= DECONV_iY;
        end
        if (h_we) begin
            h_q[n_q[LW-1:0]] <= DECONV_iH;
        end
        if (x_clr) begin
            x_q <= '{default: '0};
        end else if (x_we) begin
            x_q[n_q[LW-1:0]] <= x_wdata;
        end
    end

endmodule

// File: tb/tb_deconv.sv
// Self-checking bench for deconv: directed and random frames against an arithmetic reference model.
`timescale 1ns/1ps
module tb_deconv;

    localparam int LEN   = 8;
    localparam int ACC_W = 24;
    localparam int NY    = 2 * LEN - 1;
`ifdef DECONV_RESIDUE_CHECK_EN
    localparam bit RES_EN = 1'b1;
`else
    localparam bit RES_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              iValid, iReady, oValid, iOutReady, oLast;
    logic [15:0]       iY;
    logic [7:0]        iH;
    logic signed [7:0] ox;
    logic [1:0]        oerr;

    int ty [NY];
    int th [LEN];
    int tx [LEN];
    int terr;
    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    deconv #(
        .LEN  (LEN),
        .ACC_W(ACC_W)
    ) dut (
        .clk             (clk),
        .reset           (rst_n),
        .DECONV_iValid   (iValid),
        .DECONV_iReady   (iReady),
        .DECONV_iY       (iY),
        .DECONV_iH       (iH),
        .DECONV_oValid   (oValid),
        .DECONV_iOutReady(iOutReady),
        .DECONV_oX       (ox),
        .DECONV_oLast    (oLast),
        .DECONV_oErr     (oerr)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Recursive long division written straight from the frame definition.
    function automatic void model();
        int acc;
        int q;
        terr = 0;
        if (th[0] == 0) begin
            foreach (tx[i]) tx[i] = 0;
            terr = 1;
            return;
        end
        for (int n = 0; n < LEN; n++) begin
            acc = ty[n];
            for (int k = 1; k <= n; k++) acc -= th[k] * tx[n-k];
            q = acc / th[0];
            if (q > 127) begin
                q = 127;
                terr |= 1;
            end else if (q < -128) begin
                q = -128;
                terr |= 1;
            end
            tx[n] = q;
        end
        if (RES_EN) begin
            for (int n = LEN; n < NY; n++) begin
                acc = ty[n];
                for (int k = n - LEN + 1; k < LEN; k++) acc -= th[k] * tx[n-k];
                if (acc != 0) terr |= 2;
            end
        end
    endfunction

    function automatic int exp_latency();
        int lat;
        if (th[0] == 0) return 0;
        lat = LEN * (ACC_W + 2) + LEN * (LEN - 1) / 2;
        if (RES_EN) lat += 2 * (LEN - 1) + LEN * (LEN - 1) / 2;
        return lat;
    endfunction

    function automatic void set_ones();
        th = '{1, 2, 0, 0, 0, 0, 0, 0};
        ty = '{1, 3, 3, 3, 3, 3, 3, 3, 2, 0, 0, 0, 0, 0, 0};
    endfunction

    function automatic void gen_exact();
        int xs [LEN];
        foreach (th[i]) th[i] = int'($urandom_range(0, 31)) - 16;
        if (th[0] == 0) th[0] = 3;
        foreach (xs[i]) xs[i] = int'($urandom_range(0, 31)) - 16;
        foreach (ty[n]) begin
            ty[n] = 0;
            for (int k = 0; k < LEN; k++)
                if (n - k >= 0 && n - k < LEN) ty[n] += th[k] * xs[n-k];
        end
    endfunction

    function automatic void gen_raw();
        foreach (th[i]) th[i] = int'($urandom_range(0, 255)) - 128;
        foreach (ty[i]) ty[i] = int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic send_frame();
        for (int n = 0; n < NY; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                iValid = 1'b0;
                tick();
            end
            iValid = 1'b1;
            iY     = 16'(ty[n]);
            iH     = (n < LEN) ? 8'(th[n]) : 8'($urandom);
            chk("iready_load", int'(iReady), 1);
            tick();
        end
        iValid = 1'b0;
    endtask

    task automatic collect(input int sb, input int sl, input bit rr);
        int lat;
        int b;
        int cyc;
        int stalled;
        bit rdy;
        lat = 0;
        iValid = 1'b1;
        while (!oValid && lat < 1000) begin
            iY = 16'($urandom);
            iH = 8'($urandom);
            tick();
            lat++;
        end
        iValid = 1'b0;
        chk("latency", lat, exp_latency());
        b = 0;
        cyc = 0;
        stalled = 0;
        while (b < LEN && cyc < 300) begin
            if (b == sb && stalled < sl) begin
                rdy = 1'b0;
                stalled++;
            end else begin
                rdy = rr ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            iOutReady = rdy;
            chk("ovalid", int'(oValid), 1);
            chk($sformatf("ox[%0d]", b), int'(ox), tx[b]);
            chk("olast", int'(oLast), int'(b == LEN - 1));
            chk("oerr", int'(oerr), terr);
            if (rdy) b++;
            tick();
            cyc++;
        end
        iOutReady = 1'b0;
        chk("ovalid_after_frame", int'(oValid), 0);
        chk("iready_after_frame", int'(iReady), 1);
    endtask

    task automatic run_frame(input int sb, input int sl, input bit rr);
        model();
        send_frame();
        collect(sb, sl, rr);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst_n     = 1'b0;
        iValid    = 1'b0;
        iOutReady = 1'b0;
        iY        = '0;
        iH        = '0;
        repeat (3) tick();
        chk("iready_in_reset", int'(iReady), 0);
        rst_n = 1'b1;
        #1;
        chk("rst_iready", int'(iReady), 1);
        chk("rst_ovalid", int'(oValid), 0);
        chk("rst_ox", int'(ox), 0);
        chk("rst_olast", int'(oLast), 0);
        chk("rst_oerr", int'(oerr), 0);

        set_ones();
        run_frame(-1, 0, 1'b0);

        th = '{2, 1, 0, 0, 0, 0, 0, 0};
        ty = '{6, 1, -1, 0, 0, 0, 0, 10, 5, 0, 0, 0, 0, 0, 0};
        run_frame(-1, 0, 1'b0);

        gen_raw();
        th[0] = 0;
        run_frame(-1, 0, 1'b0);

        set_ones();
        ty[NY-1] = 1;
        run_frame(-1, 0, 1'b0);

        th = '{1, 0, 0, 0, 0, 0, 0, 0};
        foreach (ty[i]) ty[i] = 0;
        ty[0] = 200;
        run_frame(-1, 0, 1'b0);

        // Abort during the divide of x[3], then confirm a clean restart.
        set_ones();
        send_frame();
        seen = 1'b0;
        repeat (94) begin
            if (oValid) seen = 1'b1;
            tick();
        end
        rst_n = 1'b0;
        tick();
        chk("iready_mid_reset", int'(iReady), 0);
        rst_n = 1'b1;
        #1;
        chk("iready_after_reset", int'(iReady), 1);
        repeat (5) begin
            if (oValid) seen = 1'b1;
            tick();
        end
        chk("no_ovalid_after_abort", int'(seen), 0);
        set_ones();
        run_frame(-1, 0, 1'b0);

        gen_exact();
        run_frame(2, 5, 1'b0);

        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) gen_exact();
            else gen_raw();
            run_frame(int'($urandom_range(0, LEN - 1)), int'($urandom_range(0, 4)), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/deconv.md
# deconv

Sequential deconvolution block: the inverse of the fixed-length convolver. It accepts a full convolution result y (2·LEN−1 samples of 16 bits) and the kernel h (LEN samples of 8 bits), recovers the LEN-sample input sequence x by recursive long division, and streams x out. It sits on the receive side of the convolution datapath and consumes frames in exactly the format the convolver emits.

## Interface
- LEN, 8: kernel and recovered-sequence length; y frame length is 2·LEN−1.
- ACC_W, 24: signed accumulator width; must be at least 16+clog2(LEN)+1.
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- DECONV_iValid  in  1  input beat valid.
- DECONV_iReady  out  1  block can accept an input beat.
- DECONV_iY  in  16  signed y[n] for the current beat.
- DECONV_iH  in  8  signed h[n]; sampled only on beats n < LEN.
- DECONV_oValid  out  1  output beat valid.
- DECONV_iOutReady  in  1  downstream accepts the output beat.
- DECONV_oX  out  8  signed x[n].
- DECONV_oLast  out  1  marks x[LEN−1].
- DECONV_oErr  out  2  frame error flags: bit0 is divide error (h[0]==0 or saturation); bit1 is nonzero residue.

## Operation
- States: LOAD, INIT, MAC, DIV, WB, RES, OUT.
- LOAD:
  - iReady=1.
  - A beat transfers when iValid&&iReady. Beat n writes y[n], and also h[n] when n<LEN.
  - After beat 2·LEN−2 the block leaves LOAD. If h[0]==0 it sets err0, forces all x to 0, and goes to OUT. Otherwise it goes to INIT with n=0.
- Recovery of x[n], for n = 0..LEN−1:
  - INIT: acc ← sign-extended y[n].
  - MAC: n cycles, k = 1..n, acc ← acc − h[k]·x[n−k].
  - DIV: quotient = acc / h[0], truncated toward zero.
  - WB: x[n] ← quotient saturated to [−128,127]. Saturation sets err0.
  - Then n+1 → INIT. After n=LEN−1 the block goes to RES, or to OUT when residue checking is compiled out.
- RES, for n = LEN..2·LEN−2:
  - 1 init cycle: acc ← y[n].
  - (2·LEN−1−n) MAC cycles over k = n−LEN+1..LEN−1.
  - 1 compare cycle: acc≠0 sets err1.
- OUT:
  - Presents x[0..LEN−1] in order with oValid=1. A beat advances only on oValid&&iOutReady.
  - oLast=1 with x[LEN−1]. oErr is constant for the whole output frame.
  - After the last transfer the block clears the error flags and returns to LOAD.
- Arithmetic: products are 8×8 signed to 16 bits, sign-extended to ACC_W. The accumulator does not overflow within the ACC_W rules.
- iValid while iReady=0 is ignored; no beat is captured.
- LOAD fully overwrites y and h, so the arrays are not cleared between frames.

## Timing
- Reset values: iReady=0 during reset and 1 on the first cycle after reset; oValid=0, oX=0, oLast=0, oErr=0. All indices are 0 and the state is LOAD.
- Reset mid-operation, in any state, aborts the frame. No partial output is emitted.
- DIV takes exactly ACC_W cycles. The deconv_div start pulse is issued in the last MAC cycle, or in INIT when n=0.
- Cycles per x[n]: 1+n+ACC_W+1. With LEN=8 and ACC_W=24 the recovery totals 236 cycles, and RES totals 42 cycles.
- The first oValid is asserted on the cycle after the last RES compare, or after the last WB.
- With h[0]==0, the first oValid is asserted 1 cycle after the last LOAD beat.
- oX, oLast and oErr are held stable while oValid&&!iOutReady.

## Configuration
- DECONV_RESIDUE_CHECK_EN:
  - Defined: the RES state exists and err1 reports a nonzero residue, i.e. the frame is not an exact convolution with h.
  - Undefined: RES is removed, WB of x[LEN−1] goes directly to OUT, err1 is tied to 0, and y[LEN..2·LEN−2] are loaded but unused.

## Structure
- deconv_pkg holds:
  - LEN and ACC_W defaults;
  - the state encoding (one-hot: LOAD, INIT, MAC, DIV, WB, RES, OUT);
  - the error bit indices ERR_DIV=0 and ERR_RES=1.
- Sub-module deconv_div: signed sequential restoring divider.
  - Ports: start, ACC_W dividend, 8-bit divisor, done, quotient.
  - Fixed ACC_W-cycle latency; truncation toward zero.
  - Owns its own sign correction; shares clk and reset.

## Test plan
- Exact frame, no error:
  - Stimulus: h={1,2,0,0,0,0,0,0}; y={1,3,3,3,3,3,3,3,2,0,0,0,0,0,0}.
  - Response: x=eight 1s, oLast on beat 8, oErr=0.
- Non-unit h[0], negative values:
  - Stimulus: h={2,1,0…}; y={6,1,−1,0,0,0,0,10,5,0,0,0,0,0,0}.
  - Response: x={3,−1,0,0,0,0,0,5}, oErr=0.
- Divide by zero:
  - Stimulus: h[0]=0.
  - Response: x=all 0, oErr=2'b01, oValid 1 cycle after the last load beat.
- Residue and saturation:
  - Stimulus A: the exact frame above with y[14]=1.
  - Response A: x=all 1. oErr=2'b10 with the macro defined, 2'b00 without it.
  - Stimulus B: y[0]=200, h={1,0…}.
  - Response B: x[0]=127, err0=1.
- Reset mid-DIV: reset low for 1 cycle during n=3 DIV.
  - No oValid is asserted.
  - iReady=1 on the next cycle.
  - A subsequent exact frame returns eight 1s.
- Backpressure:
  - Stimulus: iOutReady low for 5 cycles while x[2] is presented.
  - Response: oX holds x[2], no beats are lost or duplicated, and 8 beats total are transferred.
